// File: rtl/grf_wb.sv
// rtl/grf_wb.sv - 32x32 register file with W-to-D bypass and a commit trace FIFO
module grf_wb #(
  parameter int TR_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [31:0] wpc,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic        tr_valid,
  input  logic        tr_ready,
  output logic [31:0] tr_pc,
  output logic [4:0]  tr_addr,
  output logic [31:0] tr_data,
  output logic [7:0]  tr_drop
);

  localparam int PW = $clog2(TR_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(TR_DEPTH);

  logic [31:0]   regs    [32];
  logic [31:0]   fifo_pc [TR_DEPTH];
  logic [4:0]    fifo_ad [TR_DEPTH];
  logic [31:0]   fifo_dt [TR_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  logic commit;
  logic full;
  logic pop;
  logic push;
  logic drop;

  assign commit = we && (wa != 5'd0);
  assign full   = (count == FULL_CNT);
  assign pop    = tr_valid && tr_ready;
  // A full FIFO still accepts a commit when the head leaves on the same edge.
  assign push   = commit && (!full || pop);
  assign drop   = commit && full && !pop;

  always_comb begin
    rd1 = regs[ra1];
    rd2 = regs[ra2];
    if (we && wa == ra1) rd1 = wd;
    if (we && wa == ra2) rd2 = wd;
    if (ra1 == 5'd0) rd1 = 32'd0;
    if (ra2 == 5'd0) rd2 = 32'd0;
  end

  assign tr_valid = (count != '0);
  assign tr_pc    = tr_valid ? fifo_pc[rd_ptr] : 32'd0;
  assign tr_addr  = tr_valid ? fifo_ad[rd_ptr] : 5'd0;
  assign tr_data  = tr_valid ? fifo_dt[rd_ptr] : 32'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      for (int i = 0; i < TR_DEPTH; i++) begin
        fifo_pc[i] <= 32'd0;
        fifo_ad[i] <= 5'd0;
        fifo_dt[i] <= 32'd0;
      end
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      tr_drop <= 8'd0;
    end else begin
      if (commit) regs[wa] <= wd;
      if (push) begin
        fifo_pc[wr_ptr] <= wpc;
        fifo_ad[wr_ptr] <= wa;
        fifo_dt[wr_ptr] <= wd;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (drop && tr_drop != 8'hFF) tr_drop <= tr_drop + 8'd1;
    end
  end

endmodule

// File: tb/tb_grf_wb.sv
// tb/tb_grf_wb.sv - self-checking bench for grf_wb: read/bypass vectors plus trace scoreboard
module tb_grf_wb;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [31:0] wpc;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        tr_valid;
  logic        tr_ready;
  logic [31:0] tr_pc;
  logic [4:0]  tr_addr;
  logic [31:0] tr_data;
  logic [7:0]  tr_drop;

  grf_wb #(.TR_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .wpc(wpc),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_pc(tr_pc),
    .tr_addr(tr_addr), .tr_data(tr_data), .tr_drop(tr_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  addr;
    logic [31:0] data;
  } tr_t;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  tr_t  sb[$];
  int   m_drop;
  int   n_tests;
  int   n_fail;
  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Checks the trace head against the expected queue, then advances one edge
  // while updating the expected queue and drop count.
  task automatic step();
    logic m_pop;
    logic m_full;
    tr_t  e;
    chk("tr_valid", {31'd0, tr_valid}, {31'd0, sb.size() > 0});
    if (sb.size() > 0) begin
      e = sb[0];
      chk("tr_pc", tr_pc, e.pc);
      chk("tr_addr", {27'd0, tr_addr}, {27'd0, e.addr});
      chk("tr_data", tr_data, e.data);
    end else begin
      chk("tr_pc_empty", tr_pc, 32'd0);
      chk("tr_addr_empty", {27'd0, tr_addr}, 32'd0);
      chk("tr_data_empty", tr_data, 32'd0);
    end
    m_full = (sb.size() == 4);
    m_pop  = (sb.size() > 0) && tr_ready;
    if (m_pop) void'(sb.pop_front());
    if (we && wa != 5'd0) begin
      if (!m_full || m_pop) sb.push_back('{pc: wpc, addr: wa, data: wd});
      else if (m_drop < 255) m_drop++;
    end
    @(posedge clk);
    #1;
    chk("tr_drop", {24'd0, tr_drop}, m_drop[31:0]);
  endtask

  task automatic commit(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    we = 1'b1; wa = a; wd = d; wpc = pc;
    step();
    we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0; n_fail = 0; m_drop = 0;
    vt[0] = '{1'b1, 5'd10, 32'hAAAA0001, 5'd10, 5'd5,  32'hAAAA0001, 32'h00001234};
    vt[1] = '{1'b0, 5'd10, 32'h00000000, 5'd10, 5'd0,  32'hAAAA0001, 32'h00000000};
    vt[2] = '{1'b1, 5'd31, 32'hDEADBEEF, 5'd31, 5'd31, 32'hDEADBEEF, 32'hDEADBEEF};
    vt[3] = '{1'b1, 5'd10, 32'h00000055, 5'd10, 5'd31, 32'h00000055, 32'hDEADBEEF};
    vt[4] = '{1'b0, 5'd10, 32'h00000099, 5'd10, 5'd10, 32'h00000055, 32'h00000055};
    vt[5] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h00000000, 32'h00000000};
    vt[6] = '{1'b1, 5'd3,  32'h00000007, 5'd4,  5'd3,  32'h00000000, 32'h00000007};
    vt[7] = '{1'b0, 5'd3,  32'h00000000, 5'd3,  5'd5,  32'h00000007, 32'h00001234};

    reset = 1'b0; we = 1'b0; wa = '0; wd = '0; wpc = '0;
    ra1 = 5'd3; ra2 = 5'd17; tr_ready = 1'b0;
    #12;
    chk("rst_rd1", rd1, 32'd0);
    chk("rst_rd2", rd2, 32'd0);
    chk("rst_valid", {31'd0, tr_valid}, 32'd0);
    chk("rst_pc", tr_pc, 32'd0);
    chk("rst_drop", {24'd0, tr_drop}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // bypass then stored value, trace head visible next cycle
    we = 1'b1; wa = 5'd5; wd = 32'h1234; wpc = 32'h3000; ra1 = 5'd5;
    #1 chk("bypass_rd1", rd1, 32'h1234);
    step();
    we = 1'b0;
    #1 chk("stored_rd1", rd1, 32'h1234);
    chk("head_valid", {31'd0, tr_valid}, 32'd1);
    chk("head_pc", tr_pc, 32'h3000);
    chk("head_addr", {27'd0, tr_addr}, 32'd5);
    tr_ready = 1'b1;
    step();

    // wa=0 write is neither stored nor traced
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; ra1 = 5'd0;
    #1 chk("wa0_rd1", rd1, 32'd0);
    step();
    we = 1'b0;
    chk("wa0_no_push", {31'd0, tr_valid}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      we = vt[i].we; wa = vt[i].wa; wd = vt[i].wd; wpc = 32'h1000 + 32'(i * 4);
      ra1 = vt[i].ra1; ra2 = vt[i].ra2;
      #1;
      chk($sformatf("vec%0d_rd1", i), rd1, vt[i].e1);
      chk($sformatf("vec%0d_rd2", i), rd2, vt[i].e2);
      step();
    end
    we = 1'b0;
    step();

    // overflow: six commits into a depth-4 FIFO with no consumer
    tr_ready = 1'b0;
    for (int i = 1; i <= 6; i++) commit(5'(i), 32'h100 + 32'(i), 32'h2000 + 32'(i * 4));
    chk("ovf_drop", {24'd0, tr_drop}, 32'd2);
    for (int i = 1; i <= 6; i++) begin
      ra1 = 5'(i);
      #1 chk($sformatf("ovf_reg%0d", i), rd1, 32'h100 + 32'(i));
    end
    tr_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("ovf_drained", {31'd0, tr_valid}, 32'd0);

    // full FIFO with simultaneous pop accepts the commit
    tr_ready = 1'b0;
    for (int i = 11; i <= 14; i++) commit(5'(i), 32'h500 + 32'(i), 32'h4000 + 32'(i));
    tr_ready = 1'b1;
    commit(5'd7, 32'h777, 32'h4700);
    chk("fullpop_drop", {24'd0, tr_drop}, 32'd2);
    for (int i = 0; i < 3; i++) step();
    chk("fullpop_last_addr", {27'd0, tr_addr}, 32'd7);
    step();

    // drop counter saturation
    tr_ready = 1'b0;
    for (int i = 0; i < 304; i++) commit(5'd8, 32'(i), 32'h5000);
    chk("drop_sat", {24'd0, tr_drop}, 32'd255);
    tr_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // asynchronous reset mid-cycle with 3 queued entries
    tr_ready = 1'b0;
    commit(5'd9, 32'hABCD, 32'h6000);
    commit(5'd12, 32'h12, 32'h6004);
    commit(5'd13, 32'h13, 32'h6008);
    ra1 = 5'd9;
    #1 chk("pre_rst_reg9", rd1, 32'hABCD);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", {31'd0, tr_valid}, 32'd0);
    chk("arst_rd9", rd1, 32'd0);
    chk("arst_drop", {24'd0, tr_drop}, 32'd0);
    sb.delete();
    m_drop = 0;
    we = 1'b1; wa = 5'd20; wd = 32'h2020; wpc = 32'h7000;
    @(posedge clk); #1;
    we = 1'b0; ra1 = 5'd20;
    #1 chk("rst_ignores_commit", rd1, 32'd0);
    chk("rst_no_push", {31'd0, tr_valid}, 32'd0);
    reset = 1'b1;
    commit(5'd20, 32'h2020, 32'h7000);
    chk("post_rst_reg20", rd1, 32'h2020);
    tr_ready = 1'b1;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
